// File: rtl/mips_fetch_unit.sv
// MIPS instruction fetch stage: FETCH/WAIT/EXEC sequencer over a variable-latency
// instruction memory, with wait timeout/reissue and next-PC selection on retire.
module mips_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [5:0]  funct,
  output logic        instr_valid,
  input  logic        retire,
  input  logic        pcsrc,
  input  logic        jump,
  input  logic [31:0] signimm,
  output logic [31:0] pc,
  output logic [31:0] pcplus4,
  output logic        fetch_err
);

  localparam int            CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] wait_cnt;
  logic [31:0]   next_pc;

  assign pcplus4   = pc + 32'd4;
  assign imem_addr = pc;
  // Gate with reset so the request drops the instant reset asserts.
  assign imem_req  = (state == S_FETCH) && !reset;
  assign op        = instr[31:26];
  assign funct     = instr[5:0];

  always_comb begin
    next_pc = pcplus4;
    if (jump)
      next_pc = {pcplus4[31:28], instr[25:0], 2'b00};
    else if (pcsrc)
      next_pc = pcplus4 + {signimm[29:0], 2'b00};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_FETCH;
      pc          <= RESET_PC;
      instr       <= 32'h0;
      instr_valid <= 1'b0;
      fetch_err   <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          wait_cnt <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          // Data arriving in the final wait cycle wins over the timeout.
          if (imem_rvalid) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            state       <= S_EXEC;
          end else if (wait_cnt == CNT_LAST) begin
            fetch_err <= 1'b1;
            state     <= S_FETCH;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_EXEC: begin
          if (retire) begin
            pc          <= next_pc;
            instr_valid <= 1'b0;
            state       <= S_FETCH;
          end
        end
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Bench for mips_fetch_unit: directed and randomized instruction transactions checked
// against a transaction-level model of PC flow, timeouts and the sticky error flag.
module tb_mips_fetch_unit;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic        instr_valid;
  logic        retire;
  logic        pcsrc;
  logic        jump;
  logic [31:0] signimm;
  logic [31:0] pc;
  logic [31:0] pcplus4;
  logic        fetch_err;

  mips_fetch_unit #(.RESET_PC(32'h0), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr(instr), .op(op),
    .funct(funct), .instr_valid(instr_valid), .retire(retire), .pcsrc(pcsrc),
    .jump(jump), .signimm(signimm), .pc(pc), .pcplus4(pcplus4), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          fails   = 0;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic        m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Architectural next-PC: sequential, branch-relative or 26-bit region jump.
  function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [31:0] ins,
                                           input logic br, input logic jp,
                                           input logic [31:0] imm);
    logic [31:0] seq;
    seq = cur + 32'd4;
    if (jp) return (seq & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 32'd4);
    if (br) return seq + imm * 32'd4;
    return seq;
  endfunction

  function automatic logic [31:0] imm_to(input logic [31:0] cur, input logic [31:0] target);
    return 32'($signed(target - cur - 32'd4) >>> 2);
  endfunction

  task automatic fetch_phase();
    chk("fetch_req", imem_req, 1);
    chk("fetch_addr", imem_addr, m_pc);
    imem_rvalid = ($urandom_range(0, 3) == 0);
    imem_rdata  = $urandom;
    step();
    imem_rvalid = 1'b0;
  endtask

  task automatic run_instr(input logic [31:0] rdata, input int delay, input int hold,
                           input logic br, input logic jp, input logic [31:0] imm);
    int k;
    k = 0;
    fetch_phase();
    for (int i = 0; i < delay; i++) begin
      chk("wait_req", imem_req, 0);
      chk("wait_vld", instr_valid, 0);
      retire = ($urandom_range(0, 2) == 0);
      step();
      retire = 1'b0;
      k++;
      chk("wait_pc", pc, m_pc);
      if (k == TO) begin
        m_err = 1'b1;
        k = 0;
        chk("timeout_err", fetch_err, m_err);
        fetch_phase();
      end
    end
    imem_rvalid = 1'b1;
    imem_rdata  = rdata;
    step();
    imem_rvalid = 1'b0;
    m_instr = rdata;
    chk("exec_vld", instr_valid, 1);
    chk("exec_instr", instr, m_instr);
    chk("exec_op", op, m_instr >> 26);
    chk("exec_funct", funct, m_instr & 32'h3F);
    chk("exec_err", fetch_err, m_err);
    chk("exec_req", imem_req, 0);
    for (int i = 0; i < hold; i++) begin
      imem_rvalid = ($urandom_range(0, 1) == 0);
      imem_rdata  = 32'hDEAD_BEEF;
      step();
      imem_rvalid = 1'b0;
      chk("hold_instr", instr, m_instr);
      chk("hold_vld", instr_valid, 1);
      chk("hold_pc", pc, m_pc);
    end
    retire  = 1'b1;
    pcsrc   = br;
    jump    = jp;
    signimm = imm;
    step();
    retire = 1'b0;
    pcsrc  = 1'b0;
    jump   = 1'b0;
    m_pc = ref_next(m_pc, m_instr, br, jp, imm);
    chk("retire_pc", pc, m_pc);
    chk("retire_pc4", pcplus4, m_pc + 32'd4);
    chk("retire_vld", instr_valid, 0);
  endtask

  initial begin
    reset = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
    retire = 1'b0; pcsrc = 1'b0; jump = 1'b0; signimm = '0;
    m_pc = 32'h0; m_instr = 32'h0; m_err = 1'b0;
    repeat (2) step();
    chk("rst_req", imem_req, 0);
    chk("rst_pc", pc, 0);
    chk("rst_instr", instr, 0);
    chk("rst_vld", instr_valid, 0);
    chk("rst_err", fetch_err, 0);
    reset = 1'b0;
    #1;

    // addi at reset PC, then advance to pc=8 for the branch cases
    run_instr(32'h2002_0005, 0, 0, 1'b0, 1'b0, 32'h0);
    chk("first_pc", pc, 32'h4);
    run_instr($urandom, 0, 0, 1'b0, 1'b0, 32'h0);
    run_instr(32'h1000_FFFE, 0, 1, 1'b1, 1'b0, 32'hFFFF_FFFE);
    chk("beq_back", pc, 32'h4);
    run_instr($urandom, 0, 0, 1'b0, 1'b0, 32'h0);
    run_instr(32'h1000_FFFE, 0, 0, 1'b0, 1'b0, 32'hFFFF_FFFE);
    chk("beq_not_taken", pc, 32'hC);

    run_instr($urandom, 1, 0, 1'b1, 1'b0, imm_to(m_pc, 32'h1000_0010));
    chk("reach_jump_pc", pc, 32'h1000_0010);
    run_instr(32'h0800_0040, 0, 0, 1'b1, 1'b1, $urandom);
    chk("jump_priority", pc, 32'h1000_0100);

    // rvalid on the last permitted wait cycle, then a genuine timeout
    run_instr($urandom, TO - 1, 0, 1'b0, 1'b0, 32'h0);
    chk("edge_no_err", fetch_err, 0);
    run_instr($urandom, TO, 1, 1'b0, 1'b0, 32'h0);
    chk("timeout_sticky", fetch_err, 1);

    for (int n = 0; n < 40; n++)
      run_instr($urandom, $urandom_range(0, 9), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                32'($signed($urandom_range(0, 64)) - 32));

    fetch_phase();
    #2;
    reset = 1'b1;
    #1;
    chk("async_vld", instr_valid, 0);
    chk("async_pc", pc, 32'h0);
    chk("async_req", imem_req, 0);
    chk("async_instr", instr, 0);
    chk("async_err", fetch_err, 0);
    repeat (2) step();
    reset = 1'b0;
    #1;
    m_pc = 32'h0;
    m_err = 1'b0;

    run_instr($urandom, 0, 0, 1'b1, 1'b0, imm_to(32'h0, 32'hFFFF_FFFC));
    chk("reach_top", pc, 32'hFFFF_FFFC);
    chk("top_pc4", pcplus4, 32'h0);
    run_instr($urandom, 2, 0, 1'b0, 1'b0, 32'h0);
    chk("wrap_pc", pc, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule

// File: doc/mips_fetch_unit.md
Name: mips_fetch_unit

Overview:
Instruction fetch stage for the MIPS processor; sits directly upstream of the controller.
- Holds the PC and requests instructions from an instruction memory whose latency is variable.
- Presents the latched instruction, plus its op and funct fields, to the controller and datapath.
- Computes the next PC from the controller's pcsrc and jump outputs when the datapath retires the current instruction.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
TIMEOUT, 15, maximum number of cycles spent in WAIT without imem_rvalid before the request is reissued.

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
imem_req  output  1  fetch request to instruction memory; high exactly while state==FETCH
imem_addr  output  32  fetch address; always equal to pc
imem_rvalid  input  1  instruction memory read data valid
imem_rdata  input  32  instruction memory read data
instr  output  32  latched instruction
op  output  6  instr[31:26], to controller
funct  output  6  instr[5:0], to controller
instr_valid  output  1  instr is valid and executing
retire  input  1  datapath finished the current instruction this cycle
pcsrc  input  1  branch taken, from controller
jump  input  1  jump, from controller
signimm  input  32  sign-extended immediate, from datapath
pc  output  32  current PC register
pcplus4  output  32  pc + 4, combinational
fetch_err  output  1  sticky flag: at least one fetch timeout has occurred

Behaviour:
- Reset (asynchronous, active-high, may assert in any state): pc=RESET_PC, instr=0, instr_valid=0, fetch_err=0, wait counter=0, state=FETCH.
- While reset is high, imem_req=0.
- States are FETCH, WAIT and EXEC.
- FETCH: imem_req=1 for one cycle; clear wait counter; next state is WAIT.
- WAIT:
  - imem_rvalid=1: instr<=imem_rdata, instr_valid<=1, next state EXEC.
  - Otherwise the counter increments. When counter==TIMEOUT-1 with no rvalid: fetch_err<=1, next state FETCH (the same pc is reissued).
  - rvalid arriving in the timeout cycle takes priority; no error is flagged.
- EXEC: instr_valid=1 and state is held until retire=1. On retire: pc<=next_pc, instr_valid<=0, next state FETCH.
- imem_rvalid seen in FETCH or EXEC is ignored; instr does not change.
- retire seen outside EXEC is ignored.
- pc changes only on retire in EXEC. instr changes only on accepted rvalid in WAIT.
- next_pc:
  - jump=1: {pcplus4[31:28], instr[25:0], 2'b00}. jump has priority over pcsrc.
  - else pcsrc=1: pcplus4 + (signimm << 2).
  - else: pcplus4.
- Arithmetic is 32-bit, modulo 2^32. pc=32'hFFFF_FFFC gives pcplus4=0. Negative signimm branches backward.
- Latency: minimum 3 cycles per instruction (FETCH, WAIT with rvalid the first cycle, EXEC with retire the first cycle).
- The first imem_req is in the first cycle after reset deasserts.
- op and funct are combinational slices of instr and are valid whenever instr_valid=1.
- fetch_err is cleared only by reset.

Test Plan:
- Reset release with RESET_PC=0: imem_req=1 and imem_addr=0 on cycle 1; rvalid with rdata=32'h2002_0005 on cycle 2 → instr_valid=1, op=6'b001000 on cycle 3; retire → pc=4, imem_req=1 next cycle.
- Branch: pc=8, instr=beq, pcsrc=1, signimm=32'hFFFF_FFFE, retire → pc=4. Same with pcsrc=0 → pc=12.
- Jump priority: pc=32'h1000_0010, instr=32'h0800_0040, jump=1 and pcsrc=1 → pc=32'h1000_0100.
- Timeout with TIMEOUT=4: no rvalid for 4 WAIT cycles → fetch_err=1, imem_req reasserted with the same address. rvalid on the retry → normal EXEC; fetch_err stays 1.
- Spurious inputs: rvalid pulsed during EXEC with rdata=32'hDEAD_BEEF → instr unchanged. retire pulsed during WAIT → pc unchanged.
- Reset asserted mid-WAIT (async, between edges) → instr_valid=0, pc=RESET_PC and imem_req=0 immediately; FETCH resumes after deassert. Also pc=32'hFFFF_FFFC, retire → pc=0.
